// File: rtl/bus_copy_master.sv
// ============================================================================
// Module   : bus_copy_master
// Purpose  : Bus initiator that copies a block of words from src to dst
//            over a single-port rd/we + ready memory interface.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_copy_master #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 16,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] src,
   input  logic [ADDR_WIDTH-1:0] dst,
   input  logic [LEN_WIDTH-1:0]  len,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [ADDR_WIDTH-1:0] m_a,
   output logic [DATA_WIDTH-1:0] m_d,
   output logic                  m_we,
   output logic                  m_rd,
   input  logic [DATA_WIDTH-1:0] m_spo,
   input  logic                  m_ready
);

   localparam int c_TW = $clog2(TIMEOUT + 1);

   localparam logic [2:0] c_IDLE    = 3'd0;
   localparam logic [2:0] c_RD_REQ  = 3'd1;
   localparam logic [2:0] c_RD_WAIT = 3'd2;
   localparam logic [2:0] c_WR_REQ  = 3'd3;
   localparam logic [2:0] c_WR_WAIT = 3'd4;
   localparam logic [2:0] c_DONE    = 3'd5;

   logic [2:0]            r_state;
   logic [2:0]            w_next;
   logic [ADDR_WIDTH-1:0] r_src;
   logic [ADDR_WIDTH-1:0] r_dst;
   logic [LEN_WIDTH-1:0]  r_cnt;
   logic [DATA_WIDTH-1:0] r_data;
   logic [c_TW-1:0]       r_tmo;
   logic                  r_err;
   logic                  w_tmo_hit;

   // One more idle wait cycle would bring the counter to TIMEOUT.
   assign w_tmo_hit = (r_tmo == c_TW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         c_IDLE: begin
            if (start) begin
               w_next = (len == '0) ? c_DONE : c_RD_REQ;
            end
         end
         c_RD_REQ: w_next = c_RD_WAIT;
         c_RD_WAIT: begin
            if (m_ready) begin
               w_next = c_WR_REQ;
            end else if (w_tmo_hit) begin
               w_next = c_DONE;
            end
         end
         c_WR_REQ: w_next = c_WR_WAIT;
         c_WR_WAIT: begin
            if (m_ready) begin
               w_next = (r_cnt == LEN_WIDTH'(1)) ? c_DONE : c_RD_REQ;
            end else if (w_tmo_hit) begin
               w_next = c_DONE;
            end
         end
         c_DONE:  w_next = c_IDLE;
         default: w_next = c_IDLE;
      endcase
   end

   always_comb begin
      busy = (r_state != c_IDLE);
      done = (r_state == c_DONE);
      m_rd = (r_state == c_RD_REQ);
      m_we = (r_state == c_WR_REQ);
      m_a  = '0;
      case (r_state)
         c_RD_REQ, c_RD_WAIT: m_a = r_src;
         c_WR_REQ, c_WR_WAIT: m_a = r_dst;
         default:             m_a = '0;
      endcase
   end

   assign m_d = r_data;
   assign err = r_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_src  <= '0;
         r_dst  <= '0;
         r_cnt  <= '0;
         r_data <= '0;
         r_tmo  <= '0;
         r_err  <= 1'b0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (start) begin
                  r_src <= src;
                  r_dst <= dst;
                  r_cnt <= len;
                  r_err <= 1'b0;
               end
            end
            c_RD_REQ, c_WR_REQ: r_tmo <= '0;
            c_RD_WAIT: begin
               if (m_ready) begin
                  r_data <= m_spo;
               end else if (w_tmo_hit) begin
                  r_err <= 1'b1;
               end else begin
                  r_tmo <= r_tmo + c_TW'(1);
               end
            end
            c_WR_WAIT: begin
               if (m_ready) begin
                  r_src <= r_src + ADDR_WIDTH'(1);
                  r_dst <= r_dst + ADDR_WIDTH'(1);
                  r_cnt <= r_cnt - LEN_WIDTH'(1);
               end else if (w_tmo_hit) begin
                  r_err <= 1'b1;
               end else begin
                  r_tmo <= r_tmo + c_TW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_bus_copy_master.sv
// ============================================================================
// Module   : tb_bus_copy_master
// Purpose  : Self-checking bench for bus_copy_master with a RAM responder
//            and a block-copy reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_copy_master;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] src = '0;
   logic [15:0] dst = '0;
   logic [15:0] len = '0;
   logic        busy, done, err, m_we, m_rd;
   logic [15:0] m_a;
   logic [31:0] m_d;
   logic [31:0] m_spo = '0;
   logic        m_ready = 1'b0;

   bus_copy_master #(
      .ADDR_WIDTH(16), .DATA_WIDTH(32), .LEN_WIDTH(16), .TIMEOUT(8)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .src(src), .dst(dst), .len(len),
      .busy(busy), .done(done), .err(err), .m_a(m_a), .m_d(m_d),
      .m_we(m_we), .m_rd(m_rd), .m_spo(m_spo), .m_ready(m_ready)
   );

   always #5 clk = ~clk;

   int          ncmp = 0;
   int          nfail = 0;
   logic [31:0] mem [0:65535];
   logic [31:0] rm  [0:65535];

   // responder state
   bit          pend = 1'b0;
   bit          req_rd;
   logic [15:0] req_a;
   logic [31:0] req_d;
   int          wcnt;
   int          wait_k = 1;
   bit          stuck = 1'b0;
   int          n_rd, n_we;
   logic [15:0] rd_log [$];
   logic [15:0] wr_log [$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // RAM responder: ready arrives in the wait_k-th wait cycle after a request.
   task automatic bus_step();
      if (!rst_n) begin
         pend    = 1'b0;
         m_ready = 1'b0;
         return;
      end
      if (done || m_ready) begin
         pend    = 1'b0;
         m_ready = 1'b0;
      end
      if (pend) begin
         wcnt++;
         chk("a_stable", m_a, req_a);
         chk("no_req_in_wait", {m_rd, m_we}, 2'b00);
         if (!req_rd) chk("d_stable", m_d, req_d);
         if (!stuck && wcnt == wait_k) begin
            m_ready = 1'b1;
            if (req_rd) m_spo = mem[req_a];
            else        mem[req_a] = req_d;
         end
      end else if (m_rd || m_we) begin
         chk("rd_we_excl", m_rd & m_we, 1'b0);
         pend   = 1'b1;
         wcnt   = 0;
         req_rd = m_rd;
         req_a  = m_a;
         req_d  = m_d;
         if (m_rd) begin n_rd++; rd_log.push_back(m_a); end
         else      begin n_we++; wr_log.push_back(m_a); end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      bus_step();
   endtask

   task automatic run(input string tag, input logic [15:0] s, input logic [15:0] d,
                      input logic [15:0] l, input int k, input bit stk, input bit poke,
                      input int exp_cyc, input bit exp_err);
      int          cyc;
      logic [15:0] idx;
      wait_k = k;
      stuck  = stk;
      n_rd = 0; n_we = 0;
      rd_log.delete(); wr_log.delete();
      rm = mem;
      if (!exp_err) begin
         for (int i = 0; i < int'(l); i++) begin
            rm[d + 16'(i)] = rm[s + 16'(i)];
         end
      end
      tick();
      src = s; dst = d; len = l; start = 1'b1;
      tick();
      start = 1'b0;
      cyc = 1;
      while (!done && cyc < 3000) begin
         tick();
         cyc++;
         if (poke && cyc == 3) begin
            start = 1'b1; src = ~s; dst = ~d; len = 16'd7;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      chk({tag, "_done_cycle"}, 64'(cyc), 64'(exp_cyc));
      chk({tag, "_err"}, err, exp_err);
      chk({tag, "_busy_at_done"}, busy, 1'b1);
      chk({tag, "_n_rd"}, 64'(n_rd), exp_err ? 64'd1 : 64'(l));
      chk({tag, "_n_we"}, 64'(n_we), exp_err ? 64'd0 : 64'(l));
      tick();
      chk({tag, "_done_width"}, done, 1'b0);
      chk({tag, "_busy_after"}, busy, 1'b0);
      chk({tag, "_err_held"}, err, exp_err);
      for (int i = -1; i <= int'(l); i++) begin
         idx = d + 16'(i);
         chk({tag, "_mem"}, mem[idx], rm[idx]);
      end
   endtask

   initial begin
      logic [15:0] rs, rl;
      int          rk;
      for (int i = 0; i < 65536; i++) mem[i] = $urandom;
      for (int i = 0; i < 4; i++) mem[16'h10 + 16'(i)] = 32'hA0 + 32'(i);

      #3;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_rdwe", {m_rd, m_we}, 2'b00);
      chk("rst_a", m_a, 16'h0);
      chk("rst_d", m_d, 32'h0);
      tick();
      #2 rst_n = 1'b1;
      tick();

      run("copy4", 16'h0010, 16'h0020, 16'd4, 1, 1'b0, 1'b0, 17, 1'b0);
      for (int i = 0; i < 4; i++) chk("copy4_val", mem[16'h20 + 16'(i)], 32'hA0 + 32'(i));
      run("len0", 16'h0030, 16'h0040, 16'd0, 1, 1'b0, 1'b0, 1, 1'b0);
      run("wait5", 16'h0100, 16'h0200, 16'd2, 5, 1'b0, 1'b0, 25, 1'b0);
      run("stuck", 16'h0300, 16'h0400, 16'd3, 1, 1'b1, 1'b0, 10, 1'b1);
      repeat (3) tick();
      chk("err_hold_idle", err, 1'b1);
      run("clr_err", 16'h0500, 16'h0600, 16'd0, 1, 1'b0, 1'b0, 1, 1'b0);
      run("wrap", 16'hFFFF, 16'h0100, 16'd2, 1, 1'b0, 1'b0, 9, 1'b0);
      chk("wrap_rd0", rd_log[0], 16'hFFFF);
      chk("wrap_rd1", rd_log[1], 16'h0000);
      chk("wrap_wr0", wr_log[0], 16'h0100);
      chk("wrap_wr1", wr_log[1], 16'h0101);
      run("k8_edge", 16'h0700, 16'h0800, 16'd1, 8, 1'b0, 1'b0, 19, 1'b0);
      run("k9_abort", 16'h0900, 16'h0A00, 16'd2, 9, 1'b0, 1'b0, 10, 1'b1);
      run("poke", 16'h0B00, 16'h0C00, 16'd3, 2, 1'b0, 1'b1, 19, 1'b0);
      chk("poke_last_wr", wr_log[2], 16'h0C02);
      run("overlap", 16'h0D00, 16'h0D02, 16'd5, 1, 1'b0, 1'b0, 21, 1'b0);
      for (int t = 0; t < 4; t++) begin
         rs = 16'($urandom);
         rl = 16'($urandom_range(1, 6));
         rk = int'($urandom_range(1, 8));
         run("rand", rs, rs + 16'($urandom_range(0, 8)), rl, rk, 1'b0, 1'b0,
             int'(rl) * 2 * (rk + 1) + 1, 1'b0);
      end

      // Drop reset while the first write is waiting for ready.
      wait_k = 5; stuck = 1'b0; n_we = 0;
      tick();
      src = 16'h0E00; dst = 16'h0F00; len = 16'd3; start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 50 && n_we == 0; c++) tick();
      chk("rstw_reached_wr", 64'(n_we), 64'd1);
      tick();
      chk("rstw_busy_pre", busy, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("rstw_busy", busy, 1'b0);
      chk("rstw_done", done, 1'b0);
      chk("rstw_err", err, 1'b0);
      chk("rstw_rdwe", {m_rd, m_we}, 2'b00);
      chk("rstw_a", m_a, 16'h0);
      chk("rstw_d", m_d, 32'h0);
      tick();
      #2 rst_n = 1'b1;
      repeat (2) tick();
      chk("rstw_idle", busy, 1'b0);
      run("after_rst", 16'h1000, 16'h1100, 16'd2, 1, 1'b0, 1'b0, 9, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule

`default_nettype wire
